// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - EL2 shared types: trace packet and trace buffer entry (EL2_TRACE_TSTAMP_EN appends tstamp)
package el2_pkg;

   typedef struct packed {
      logic        trace_rv_i_valid_ip;
      logic        trace_rv_i_exception_ip;
      logic [4:0]  trace_rv_i_ecause_ip;
      logic        trace_rv_i_interrupt_ip;
      logic [31:0] trace_rv_i_insn_ip;
      logic [31:0] trace_rv_i_address_ip;
      logic [31:0] trace_rv_i_tval_ip;
   } el2_trace_pkt_t;

   // lost marks the first entry stored after a gap in the stream
   typedef struct packed {
      logic        lost;
      logic        exception;
      logic [4:0]  ecause;
      logic        interrupt;
      logic [31:0] insn;
      logic [31:0] address;
      logic [31:0] tval;
`ifdef EL2_TRACE_TSTAMP_EN
      logic [15:0] tstamp;
`endif
   } el2_trace_entry_t;

`ifdef EL2_TRACE_TSTAMP_EN
   localparam int EL2_TRACE_ENTRY_W = 120;
`else
   localparam int EL2_TRACE_ENTRY_W = 104;
`endif

endpackage

// File: rtl/el2_trace_fifo_ram.sv
// rtl/el2_trace_fifo_ram.sv - DEPTH x WIDTH trace storage, synchronous write, asynchronous read
module el2_trace_fifo_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 104,
   localparam int         AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/el2_trace_buf.sv
// rtl/el2_trace_buf.sv - retirement trace sink: circular FIFO with drop counting and lost marking
// Optional EL2_TRACE_TSTAMP_EN adds a free-running 16-bit capture timestamp to each entry.
module el2_trace_buf
   import el2_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int         PTR_W = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_l,
   input  logic                         trace_en,
   input  logic                         flush,
   input  el2_trace_pkt_t               trace_pkt,
   input  logic                         rd_ready,
   output logic                         rd_valid,
   output logic [EL2_TRACE_ENTRY_W-1:0] rd_data,
   output logic [PTR_W:0]               count,
   output logic                         full,
   output logic [15:0]                  drop_cnt,
   output logic                         overflow
);

   localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

   el2_trace_entry_t wr_entry;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             push, pop, wr_en, drop, lost_pend;

   assign rd_valid = (cnt_q != '0);
   assign full     = (cnt_q == FULL_CNT);
   assign count    = cnt_q;

   assign push  = trace_en & trace_pkt.trace_rv_i_valid_ip & ~flush;
   assign pop   = rd_valid & rd_ready & ~flush;
   // a same-cycle pop frees the slot, so a full FIFO only drops when nobody reads
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

`ifdef EL2_TRACE_TSTAMP_EN
   logic [15:0] tstamp_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)     tstamp_q <= '0;
      else if (flush) tstamp_q <= '0;
      else            tstamp_q <= tstamp_q + 16'd1;
   end
`endif

   always_comb begin
      wr_entry.lost      = lost_pend;
      wr_entry.exception = trace_pkt.trace_rv_i_exception_ip;
      wr_entry.ecause    = trace_pkt.trace_rv_i_ecause_ip;
      wr_entry.interrupt = trace_pkt.trace_rv_i_interrupt_ip;
      wr_entry.insn      = trace_pkt.trace_rv_i_insn_ip;
      wr_entry.address   = trace_pkt.trace_rv_i_address_ip;
      wr_entry.tval      = trace_pkt.trace_rv_i_tval_ip;
`ifdef EL2_TRACE_TSTAMP_EN
      wr_entry.tstamp    = tstamp_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt_q     <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
         lost_pend <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt_q     <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
         lost_pend <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         cnt_q <= cnt_d;
         if (drop) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            overflow  <= 1'b1;
            lost_pend <= 1'b1;
         end else if (wr_en) begin
            lost_pend <= 1'b0;
         end
      end
   end

   el2_trace_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EL2_TRACE_ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_el2_trace_buf.sv
// tb/tb_el2_trace_buf.sv - self-checking bench for el2_trace_buf against a queue-based reference model
module tb_el2_trace_buf;
   import el2_pkg::*;

   localparam int DEPTH = 16;
   localparam int EW    = EL2_TRACE_ENTRY_W;

   logic           clk = 1'b0;
   logic           rst_l = 1'b0;
   logic           trace_en = 1'b0;
   logic           flush = 1'b0;
   logic           rd_ready = 1'b0;
   el2_trace_pkt_t trace_pkt = '0;
   logic           rd_valid;
   logic [EW-1:0]  rd_data;
   logic [4:0]     count;
   logic           full;
   logic [15:0]    drop_cnt;
   logic           overflow;

   always #5 clk = ~clk;

   el2_trace_buf #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_l    (rst_l),
      .trace_en (trace_en),
      .flush    (flush),
      .trace_pkt(trace_pkt),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .count    (count),
      .full     (full),
      .drop_cnt (drop_cnt),
      .overflow (overflow)
   );

   int            n_cmp = 0;
   int            n_err = 0;
   logic [103:0]  mq[$];
   int            m_drops = 0;
   bit            m_ovf = 0;
   bit            m_lost = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [103:0] mk_entry(input bit lost, input el2_trace_pkt_t p);
      return {lost, p.trace_rv_i_exception_ip, p.trace_rv_i_ecause_ip, p.trace_rv_i_interrupt_ip,
              p.trace_rv_i_insn_ip, p.trace_rv_i_address_ip, p.trace_rv_i_tval_ip};
   endfunction

   task automatic model_clear();
      mq.delete();
      m_drops = 0;
      m_ovf   = 0;
      m_lost  = 0;
   endtask

   task automatic model_edge();
      int sz;
      bit do_pop, do_push;
      if (flush) begin
         model_clear();
         return;
      end
      sz      = mq.size();
      do_pop  = (sz != 0) && rd_ready;
      do_push = trace_en && trace_pkt.trace_rv_i_valid_ip;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (sz < DEPTH || do_pop) begin
            mq.push_back(mk_entry(m_lost, trace_pkt));
            m_lost = 0;
         end else begin
            if (m_drops < 65535) m_drops++;
            m_ovf  = 1;
            m_lost = 1;
         end
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".rd_valid"}, rd_valid, mq.size() != 0);
      check({tag, ".count"}, count, mq.size());
      check({tag, ".full"}, full, mq.size() == DEPTH);
      check({tag, ".drop_cnt"}, drop_cnt, m_drops);
      check({tag, ".overflow"}, overflow, m_ovf);
      if (mq.size() != 0) check({tag, ".rd_data"}, rd_data, mq[0]);
   endtask

   task automatic drive(input bit ten, input bit vld, input bit fl, input bit rdy, input logic [31:0] addr);
      trace_en = ten;
      flush    = fl;
      rd_ready = rdy;
      trace_pkt.trace_rv_i_valid_ip     = vld;
      trace_pkt.trace_rv_i_exception_ip = 1'($urandom);
      trace_pkt.trace_rv_i_ecause_ip    = 5'($urandom);
      trace_pkt.trace_rv_i_interrupt_ip = 1'($urandom);
      trace_pkt.trace_rv_i_insn_ip      = $urandom();
      trace_pkt.trace_rv_i_address_ip   = addr;
      trace_pkt.trace_rv_i_tval_ip      = $urandom();
   endtask

   // check at negedge, advance the model, then step past the active edge
   task automatic cycle();
      @(negedge clk);
      check_state("cyc");
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst.rd_valid", rd_valid, 0);
      check("rst.count", count, 0);
      check("rst.full", full, 0);
      check("rst.drop_cnt", drop_cnt, 0);
      check("rst.overflow", overflow, 0);
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      model_clear();

      // three in-order packets, one-cycle write-to-read latency
      drive(1, 1, 0, 0, 32'h100);
      cycle();
      check("t1.valid_lat", rd_valid, 1);
      drive(1, 1, 0, 0, 32'h104);
      cycle();
      drive(1, 1, 0, 0, 32'h108);
      cycle();
      check("t1.count", count, 3);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 32'h0);
         check("t1.addr", rd_data[63:32], 32'h100 + 4 * i);
         check("t1.lost", rd_data[103], 0);
         cycle();
      end
      check("t1.empty", rd_valid, 0);

      // overflow and lost marking
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 0, 32'h1000 + 4 * i);
         cycle();
      end
      check("t2.full", full, 1);
      check("t2.count", count, 16);
      check("t2.drop_cnt", drop_cnt, 4);
      check("t2.overflow", overflow, 1);
      drive(0, 0, 0, 1, 0); cycle();
      drive(1, 1, 0, 0, 32'h2000); cycle();
      drive(1, 1, 0, 1, 32'h2004); cycle();
      for (int i = 0; i < 14; i++) begin
         drive(0, 0, 0, 1, 0);
         cycle();
      end
      check("t2.lost_addr", rd_data[63:32], 32'h2000);
      check("t2.lost_set", rd_data[103], 1);
      cycle();
      check("t2.next_addr", rd_data[63:32], 32'h2004);
      check("t2.lost_clr", rd_data[103], 0);
      cycle();
      check("t2.drained", rd_valid, 0);

      // simultaneous push and pop while full
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 0, 0, 32'h200 + 4 * i);
         cycle();
      end
      check("t3.count_pre", count, 16);
      drive(1, 1, 0, 1, 32'h300);
      check("t3.oldest", rd_data[63:32], 32'h200);
      cycle();
      check("t3.count", count, 16);
      check("t3.drop_cnt", drop_cnt, 4);
      check("t3.next", rd_data[63:32], 32'h204);

      // disabled capture and invalid packets are neither stored nor dropped
      drive(0, 0, 1, 0, 0); cycle();
      for (int i = 0; i < 10; i++) begin
         drive(i >= 5, i < 5, 0, 0, 32'h400 + i);
         cycle();
         check("t4.count", count, 0);
         check("t4.drop_cnt", drop_cnt, 0);
      end

      // flush beats a concurrent push
      for (int i = 0; i < 18; i++) begin
         drive(1, 1, 0, 0, 32'h500 + 4 * i);
         cycle();
      end
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 0, 1, 0);
         cycle();
      end
      check("t5.count_pre", count, 7);
      check("t5.drop_pre", drop_cnt, 2);
      drive(1, 1, 1, 1, 32'h600);
      cycle();
      check("t5.count", count, 0);
      check("t5.drop_cnt", drop_cnt, 0);
      check("t5.overflow", overflow, 0);
      check("t5.rd_valid", rd_valid, 0);

      // randomized traffic with varying drain pressure
      for (int blk = 0; blk < 12; blk++) begin
         int rdy_pct;
         case (blk % 4)
            0:       rdy_pct = 10;
            1:       rdy_pct = 50;
            2:       rdy_pct = 90;
            default: rdy_pct = 60;
         endcase
         for (int i = 0; i < 200; i++) begin
            drive($urandom_range(99) < 90, $urandom_range(99) < 70, $urandom_range(127) == 0,
                  $urandom_range(99) < rdy_pct, $urandom());
            cycle();
         end
      end

      // asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 0, 32'h700 + 4 * i);
         cycle();
      end
      #2;
      rst_l = 1'b0;
      #1;
      check("arst.rd_valid", rd_valid, 0);
      check("arst.count", count, 0);
      check("arst.full", full, 0);
      check("arst.drop_cnt", drop_cnt, 0);
      check("arst.overflow", overflow, 0);
      model_clear();
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, i == 2, 32'h800 + 4 * i);
         cycle();
      end
      drive(0, 0, 0, 0, 0);
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
